// File: rtl/riscv_soc_pkg.sv
// Shared types and constants for the riscv_kernel host controller.
package riscv_soc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    READBACK,
    DONE
  } state_e;

  localparam logic WR_SEL_IMEM = 1'b0;
  localparam logic WR_SEL_DMEM = 1'b1;

  localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/dual_owner_ram.sv
// Single-port RAM shared by kernel and host; kernel_owns picks which side drives it.
// Read is asynchronous because the kernel captures q0 in the same cycle as its address.
module dual_owner_ram #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          kernel_owns,
  input  logic [AW-1:0] k_addr,
  input  logic          k_we,
  input  logic [DW-1:0] k_wdata,
  input  logic [AW-1:0] h_addr,
  input  logic          h_we,
  input  logic [DW-1:0] h_wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;

  always_comb begin
    addr  = kernel_owns ? k_addr  : h_addr;
    we    = kernel_owns ? k_we    : h_we;
    wdata = kernel_owns ? k_wdata : h_wdata;
  end

  // Contents are deliberately not reset so a reset mid-run keeps partial results.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/riscv_kernel_host_ctrl.sv
// Host-side controller for the riscv_kernel: loads memories, runs the kernel,
// drains late stores and streams dmem back over a valid/ready channel.
module riscv_kernel_host_ctrl
  import riscv_soc_pkg::*;
#(
  parameter int IMEM_AW      = 6,
  parameter int DMEM_AW      = 5,
  parameter int DW           = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int MAX_CYCLES   = 4096,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               wr_sel,
  input  logic [IMEM_AW-1:0] wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               run_req,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DW-1:0]      rd_data,
  output logic               rd_last,
  output logic               busy,
  output logic               done_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic               ap_rst,
  output logic               ap_start,
  input  logic               ap_done,
  input  logic               ap_idle,
  input  logic [IMEM_AW-1:0] imem_address0,
  input  logic               imem_ce0,
  output logic [DW-1:0]      imem_q0,
  input  logic [DMEM_AW-1:0] dmem_address0,
  input  logic               dmem_ce0,
  input  logic               dmem_we0,
  input  logic [DW-1:0]      dmem_d0,
  output logic [DW-1:0]      dmem_q0
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [DMEM_AW-1:0] rd_addr_q, rd_addr_d;
  logic               timeout_q, timeout_d;
  logic               ap_start_q, ap_start_d;
  logic               wr_ready_q, wr_ready_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               kernel_owns;
  logic               host_we;
  logic [DMEM_AW-1:0] dmem_host_addr;
  logic [DW-1:0]      dmem_rdata;
  logic               unused_inputs;

  // Status-only kernel signals; nothing in the controller depends on them.
  assign unused_inputs = ^{ap_idle, imem_ce0, dmem_ce0};

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rd_addr_d   = rd_addr_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE, DONE: begin
        if (run_req) begin
          state_d     = RUN;
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
        end
      end
      RUN: begin
        if (cycle_cnt_q != {CNT_W{1'b1}}) cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (ap_done) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
          timeout_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          state_d   = READBACK;
          rd_addr_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      READBACK: begin
        if (rd_ready) begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == {DMEM_AW{1'b1}}) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered off the next state so they line up with state_q.
    ap_start_d = !(state_d == RUN || state_d == DRAIN);
    wr_ready_d = (state_d == IDLE || state_d == DONE);
    rd_valid_d = (state_d == READBACK);
    rd_last_d  = (state_d == READBACK) && (rd_addr_d == {DMEM_AW{1'b1}});
    busy_d     = !(state_d == IDLE || state_d == DONE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      drain_cnt_q <= '0;
      rd_addr_q   <= '0;
      timeout_q   <= 1'b0;
      ap_start_q  <= 1'b1;
      wr_ready_q  <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_addr_q   <= rd_addr_d;
      timeout_q   <= timeout_d;
      ap_start_q  <= ap_start_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign kernel_owns    = (state_q == RUN) || (state_q == DRAIN);
  assign host_we        = wr_valid && wr_ready_q;
  assign dmem_host_addr = rd_valid_q ? rd_addr_q : wr_addr[DMEM_AW-1:0];

  dual_owner_ram #(.AW(IMEM_AW), .DW(DW)) u_imem (
    .clk         (clk),
    .kernel_owns (kernel_owns),
    .k_addr      (imem_address0),
    .k_we        (1'b0),
    .k_wdata     ({DW{1'b0}}),
    .h_addr      (wr_addr),
    .h_we        (host_we && (wr_sel == WR_SEL_IMEM)),
    .h_wdata     (wr_data),
    .rdata       (imem_q0)
  );

  dual_owner_ram #(.AW(DMEM_AW), .DW(DW)) u_dmem (
    .clk         (clk),
    .kernel_owns (kernel_owns),
    .k_addr      (dmem_address0),
    .k_we        (dmem_we0),
    .k_wdata     (dmem_d0),
    .h_addr      (dmem_host_addr),
    .h_we        (host_we && (wr_sel == WR_SEL_DMEM)),
    .h_wdata     (wr_data),
    .rdata       (dmem_rdata)
  );

  assign dmem_q0   = dmem_rdata;
  assign rd_data   = dmem_rdata;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign cycle_cnt = cycle_cnt_q;
  assign ap_start  = ap_start_q;
  assign ap_rst    = rst;

endmodule

// File: tb/tb_riscv_kernel_host_ctrl.sv
// Directed bench for riscv_kernel_host_ctrl with a tiny addi/sw kernel model.
module tb_riscv_kernel_host_ctrl;

  localparam int IMEM_AW = 6;
  localparam int DMEM_AW = 5;
  localparam int DW      = 32;
  localparam int MAXC    = 64;
  localparam int CNT_W   = 32;
  localparam logic [IMEM_AW-1:0] END_PC = 6'd8;
  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_SW   = 32'h00102023;  // sw x1,0(x0)
  localparam logic [31:0] I_NOP  = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               wr_valid = 1'b0, wr_ready, wr_sel = 1'b0;
  logic [IMEM_AW-1:0] wr_addr = '0;
  logic [DW-1:0]      wr_data = '0;
  logic               run_req = 1'b0;
  logic               rd_valid, rd_ready = 1'b0, rd_last;
  logic [DW-1:0]      rd_data;
  logic               busy, done_o, timeout_o;
  logic [CNT_W-1:0]   cycle_cnt;
  logic               ap_rst, ap_start, ap_done, ap_idle;
  logic [IMEM_AW-1:0] imem_address0;
  logic               imem_ce0, dmem_ce0, dmem_we0;
  logic [DW-1:0]      imem_q0, dmem_d0, dmem_q0;
  logic [DMEM_AW-1:0] dmem_address0;

  riscv_kernel_host_ctrl #(
    .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .DW(DW),
    .DRAIN_CYCLES(4), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .run_req(run_req),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done_o(done_o), .timeout_o(timeout_o), .cycle_cnt(cycle_cnt),
    .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .imem_address0(imem_address0), .imem_ce0(imem_ce0), .imem_q0(imem_q0),
    .dmem_address0(dmem_address0), .dmem_ce0(dmem_ce0), .dmem_we0(dmem_we0),
    .dmem_d0(dmem_d0), .dmem_q0(dmem_q0)
  );

  // Kernel model: executes addi/sw one per cycle, ap_done when pc reaches END_PC.
  logic [IMEM_AW-1:0] pc;
  logic [31:0]        xr [32];
  logic               bfm_hang = 1'b0;
  logic               ovr_we = 1'b0;
  logic [4:0]         ovr_addr = '0;
  logic [31:0]        ovr_data = '0;
  logic [31:0]        ins, simm_i, simm_s;
  logic               is_sw, is_addi;

  assign ins      = imem_q0;
  assign simm_i   = {{20{ins[31]}}, ins[31:20]};
  assign simm_s   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign is_sw    = (ins[6:0] == 7'h23) && (ins[14:12] == 3'b010);
  assign is_addi  = (ins[6:0] == 7'h13) && (ins[14:12] == 3'b000);
  assign imem_address0 = pc;
  assign imem_ce0 = 1'b1;
  assign dmem_ce0 = 1'b1;
  assign ap_idle  = ap_start;
  assign ap_done  = !ap_start && !bfm_hang && (pc == END_PC);
  assign dmem_we0 = ovr_we || (!ap_start && (pc != END_PC) && is_sw);
  assign dmem_address0 = ovr_we ? ovr_addr : DMEM_AW'((xr[ins[19:15]] + simm_s) >> 2);
  assign dmem_d0  = ovr_we ? ovr_data : xr[ins[24:20]];

  always @(posedge clk) begin
    if (ap_start) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) xr[i] <= '0;
    end else if (pc != END_PC) begin
      if (is_addi && ins[11:7] != 5'd0) xr[ins[11:7]] <= xr[ins[19:15]] + simm_i;
      pc <= pc + 1'b1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_dmem [32];
  logic [31:0] rb [32];
  int          hs_cnt, last_idx, last_cnt;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic sel, input int addr, input logic [31:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_addr  = IMEM_AW'(addr);
    wr_data  = data;
    step;
    wr_valid = 1'b0;
  endtask

  task automatic start_run;
    run_req = 1'b1;
    step;
    run_req = 1'b0;
  endtask

  task automatic wait_rb(output bit seen_done);
    int g;
    g = 0;
    seen_done = 0;
    while (!rd_valid && g < 300) begin
      if (ap_done) seen_done = 1;
      step;
      g++;
    end
    if (!rd_valid) begin
      checks++; errors++;
      $display("FAIL wait_readback: rd_valid=%0b after %0d cycles, required 1", rd_valid, g);
    end
  endtask

  task automatic collect(input bit stall);
    bit          pend;
    logic [31:0] held;
    int          g;
    hs_cnt = 0; last_idx = -1; last_cnt = 0; pend = 0; held = '0; g = 0;
    while (hs_cnt < 32 && g < 400) begin
      rd_ready = stall ? ((g % 4 == 0) || (g % 4 == 3)) : 1'b1;
      if (pend) begin
        checks++;
        if (rd_data !== held) begin
          errors++;
          $display("FAIL rd_stable: rd_data=%h after stall, required %h", rd_data, held);
        end
      end
      pend = rd_valid && !rd_ready;
      held = rd_data;
      if (rd_valid && rd_ready) begin
        rb[hs_cnt] = rd_data;
        if (rd_last) begin last_idx = hs_cnt; last_cnt++; end
        hs_cnt++;
      end
      step;
      g++;
    end
    rd_ready = 1'b0;
  endtask

  task automatic check_readback(input string tag);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rb[i] !== exp_dmem[i]) begin
        errors++;
        $display("FAIL %s word%0d: got %h, required %h", tag, i, rb[i], exp_dmem[i]);
      end
    end
    checks++;
    if (hs_cnt !== 32 || last_idx !== 31 || last_cnt !== 1) begin
      errors++;
      $display("FAIL %s handshakes: got %0d (last at %0d, %0d lasts), required 32 (last at 31, 1 last)",
               tag, hs_cnt, last_idx, last_cnt);
    end
    checks++;
    if (done_o !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done_o=%b busy=%b rd_valid=%b, required 1 0 0", tag, done_o, busy, rd_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    checks++;
    if (ap_rst !== 1'b1 || ap_start !== 1'b1 || wr_ready !== 1'b1 || rd_valid !== 1'b0 ||
        rd_last !== 1'b0 || busy !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0 || cycle_cnt !== '0) begin
      errors++;
      $display("FAIL reset: ap_rst=%b ap_start=%b wr_ready=%b rd_valid=%b rd_last=%b busy=%b done=%b to=%b cnt=%0d, required 1 1 1 0 0 0 0 0 0",
               ap_rst, ap_start, wr_ready, rd_valid, rd_last, busy, done_o, timeout_o, cycle_cnt);
    end
    rst = 1'b0;
    step;
    checks++;
    if (ap_rst !== 1'b0 || ap_start !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ap_rst=%b ap_start=%b busy=%b, required 0 1 0", ap_rst, ap_start, busy);
    end
  endtask

  task automatic test_basic;
    bit seen;
    for (int i = 0; i < 64; i++)
      host_write(1'b0, i, (i == 0) ? I_ADDI : (i == 1) ? I_SW : I_NOP);
    for (int i = 0; i < 32; i++) begin
      host_write(1'b1, i, 32'h0);
      exp_dmem[i] = 32'h0;
    end
    start_run;
    checks++;
    if (ap_start !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: ap_start=%b busy=%b wr_ready=%b, required 0 1 0", ap_start, busy, wr_ready);
    end
    wait_rb(seen);
    exp_dmem[0] = 32'd5;
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL ap_done_seen: got %b, required 1", seen);
    end
    checks++;
    if (cycle_cnt !== 32'd9 || timeout_o !== 1'b0 || ap_start !== 1'b1) begin
      errors++;
      $display("FAIL basic_status: cycle_cnt=%0d timeout=%b ap_start=%b, required 9 0 1", cycle_cnt, timeout_o, ap_start);
    end
    collect(1'b0);
    check_readback("basic");
  endtask

  task automatic test_timeout;
    bit seen;
    bfm_hang = 1'b1;
    start_run;
    wait_rb(seen);
    checks++;
    if (timeout_o !== 1'b1 || cycle_cnt !== 32'd64) begin
      errors++;
      $display("FAIL timeout: timeout_o=%b cycle_cnt=%0d, required 1 64", timeout_o, cycle_cnt);
    end
    bfm_hang = 1'b0;
    collect(1'b0);
    check_readback("timeout");
  endtask

  task automatic test_readback_stall;
    bit seen;
    for (int i = 0; i < 32; i++) begin
      host_write(1'b1, i, 32'h1000 + i);
      exp_dmem[i] = 32'h1000 + i;
    end
    start_run;
    wait_rb(seen);
    exp_dmem[0] = 32'd5;
    collect(1'b1);
    check_readback("stall");
  endtask

  task automatic test_write_blocked;
    bit seen;
    start_run;
    wr_valid = 1'b1; wr_sel = 1'b1; wr_addr = 6'd3; wr_data = 32'hDEAD;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready_in_run: got %b, required 0", wr_ready);
    end
    step; step; step;
    wr_valid = 1'b0;
    wait_rb(seen);
    collect(1'b0);
    check_readback("wr_blocked");
  endtask

  task automatic late_store(input int d);
    int g;
    bit seen;
    start_run;
    g = 0;
    while (!ap_done && g < 100) begin step; g++; end
    checks++;
    if (ap_done !== 1'b1) begin
      errors++;
      $display("FAIL late_store_done: ap_done=%b, required 1", ap_done);
    end
    repeat (d) step;
    ovr_we = 1'b1; ovr_addr = 5'd7; ovr_data = 32'hA5A5A5A5;
    step;
    ovr_we = 1'b0;
    wait_rb(seen);
    collect(1'b0);
  endtask

  task automatic test_late_store;
    late_store(3);
    exp_dmem[7] = 32'hA5A5A5A5;
    check_readback("store_in_drain");
    host_write(1'b1, 7, 32'h0);
    exp_dmem[7] = 32'h0;
    late_store(5);
    check_readback("store_after_drain");
  endtask

  task automatic test_reset_mid_run;
    bfm_hang = 1'b1;
    start_run;
    repeat (5) step;
    rst = 1'b1;
    step;
    checks++;
    if (busy !== 1'b0 || ap_start !== 1'b1 || cycle_cnt !== '0 || wr_ready !== 1'b1 || ap_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b ap_start=%b cnt=%0d wr_ready=%b ap_rst=%b, required 0 1 0 1 1",
               busy, ap_start, cycle_cnt, wr_ready, ap_rst);
    end
    rst = 1'b0;
    bfm_hang = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    bit seen;
    start_run;
    wait_rb(seen);
    collect(1'b0);
    check_readback("rerun_a");
    start_run;
    checks++;
    if (busy !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL rerun_from_done: busy=%b done_o=%b, required 1 0", busy, done_o);
    end
    wait_rb(seen);
    collect(1'b0);
    check_readback("rerun_b");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_timeout;
    test_readback_stall;
    test_write_blocked;
    test_late_store;
    test_reset_mid_run;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
